reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (1..64).
REQ-002 Parameter DEPTH, default 16, number of entries (2..256).
REQ-003 Parameter BYPASS, default 1, 1 = write-first read, 0 = read-first read.
REQ-004 Derived constant AW = clog2(DEPTH), address width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 we  input  1  write request.
REQ-008 waddr  input  AW  write address.
REQ-009 wdata  input  WIDTH  write data.
REQ-010 ra0  input  AW  read port 0 address.
REQ-011 rd0  output  WIDTH  read port 0 data, registered.
REQ-012 ra1  input  AW  read port 1 address.
REQ-013 rd1  output  WIDTH  read port 1 data, registered.
REQ-014 clr_req  input  1  request a full-array clear.
REQ-015 busy  output  1  clear in progress; writes blocked.
REQ-016 clr_done  output  1  one-cycle pulse when a clear completes.

Function
REQ-017 Write SHALL occur at the edge where we=1, busy=0, clr_req=0 and waddr<DEPTH; otherwise the array is unchanged.
REQ-018 Writes with waddr>=DEPTH SHALL be dropped silently.
REQ-019 Reads SHALL have 1-cycle latency: rdN after edge k = entry raN sampled at edge k.
REQ-020 raN>=DEPTH SHALL return 0.
REQ-021 BYPASS=1: a write accepted at edge k to address raN SHALL make rdN show wdata after edge k; BYPASS=0: rdN shows the pre-write value.
REQ-022 Both read ports SHALL operate independently, including same address.
REQ-023 Clear FSM states: IDLE, CLEAR.
REQ-024 IDLE -> CLEAR at the edge where clr_req=1; pointer loads 0; busy=1 from the next cycle.
REQ-025 CLEAR: one entry zeroed per cycle, pointer 0..DEPTH-1; exactly DEPTH cycles with busy=1.
REQ-026 At the edge zeroing entry DEPTH-1: state -> IDLE, busy -> 0, clr_done=1 for exactly one cycle.
REQ-027 clr_req while in CLEAR SHALL be ignored (no restart, no extension).
REQ-028 clr_req and we in the same IDLE cycle: clr_req wins, write dropped.
REQ-029 Reads during CLEAR SHALL return current contents (cleared entries read 0); bypass inactive since no writes are accepted.
REQ-030 clr_req may assert again in the cycle clr_done is high; FSM re-enters CLEAR at that edge.

Reset
REQ-031 rst_n=0 at an edge: rd0=0, rd1=0, busy=0, clr_done=0, state IDLE, pointer 0.
REQ-032 Reset SHALL NOT alter array contents; software uses clr_req for a known state.
REQ-033 Reset mid-clear SHALL abort: IDLE, busy=0, no clr_done, entries left partially cleared.
REQ-034 During reset, we and clr_req SHALL be ignored.

Structure
REQ-035 Package reg_file_pkg SHALL hold FSM state encoding (IDLE=0, CLEAR=1) and the clog2 helper.
REQ-036 Clear sequencer SHALL be sub-module reg_file_clr_fsm (state, pointer, busy, clr_done); array and read ports stay in reg_file.
REQ-037 Array SHALL be inferable as distributed RAM/registers; no vendor primitives.

Verification (WIDTH=8, DEPTH=16)
REQ-038 Write 0xA5 to addr 3, next cycle ra0=3 -> rd0=0xA5 one cycle later.
REQ-039 BYPASS=1: we=1 waddr=5 wdata=0x3C with ra1=5 same cycle -> rd1=0x3C next cycle; BYPASS=0 -> old value.
REQ-040 clr_req pulse after filling all entries -> busy high 16 cycles, clr_done one cycle, all 16 entries read 0x00; we=1 during busy leaves entries 0.
REQ-041 clr_req with we (addr 7, 0xFF) same cycle -> entry 7 reads 0x00 after clear.
REQ-042 rst_n=0 at clear cycle 5 -> busy=0, no clr_done, entries 0..4 read 0, entries 5..15 keep prior values.
REQ-043 waddr=0 and ra0=ra1=0 with 0x11 -> rd0=rd1=0x11; write to waddr 20 (DEPTH=16 with AW=5 build) ignored, ra0=20 -> rd0=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the register file.
// Holds the clear-sequencer state encoding and clog2.
package reg_file_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Clear sequencer: walks a pointer over every entry,
// raising busy while it runs and pulsing clr_done at the end.
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done,
  output logic          clr_we,
  output logic [PW-1:0] ptr
);

  clr_state_t    r_state;
  clr_state_t    w_next;
  logic [PW-1:0] r_ptr;
  logic          r_done;
  logic          w_last;

  assign w_last = (r_ptr == PW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (clr_req) w_next = ST_CLEAR;
      ST_CLEAR: if (w_last)  w_next = ST_IDLE;
    endcase
  end

  // Pointer parks at 0 in IDLE so a new clear starts at entry 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_CLEAR) && w_last;
      if (r_state == ST_IDLE) r_ptr <= '0;
      else                    r_ptr <= r_ptr + PW'(1);
    end
  end

  always_comb begin
    busy     = (r_state == ST_CLEAR);
    clr_we   = (r_state == ST_CLEAR);
    clr_done = r_done;
    ptr      = r_ptr;
  end

endmodule

// File: rtl/reg_file.sv
// Parameterised 1W/2R register file with registered reads,
// optional write-first bypass and a sequenced full clear.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int BYPASS = 1,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra0,
  output logic [WIDTH-1:0] rd0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd1,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done
);

  localparam int IW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd0;
  logic [WIDTH-1:0] r_rd1;
  logic [WIDTH-1:0] w_rd0;
  logic [WIDTH-1:0] w_rd1;
  logic [IW-1:0]    w_ptr;
  logic             w_busy;
  logic             w_done;
  logic             w_clr_we;
  logic             w_wr_ok;
  logic             w_ra0_ok;
  logic             w_ra1_ok;

  reg_file_clr_fsm #(
    .DEPTH (DEPTH),
    .PW    (IW)
  ) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (w_busy),
    .clr_done (w_done),
    .clr_we   (w_clr_we),
    .ptr      (w_ptr)
  );

  assign w_wr_ok  = we && !w_busy && !clr_req &&
                    (int'(waddr) < DEPTH);
  assign w_ra0_ok = (int'(ra0) < DEPTH);
  assign w_ra1_ok = (int'(ra1) < DEPTH);

  // Contents survive reset; only the clear sequence zeroes them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_clr_we)
        r_mem[w_ptr] <= '0;
      else if (w_wr_ok)
        r_mem[waddr[IW-1:0]] <= wdata;
    end
  end

  always_comb begin
    w_rd0 = '0;
    if (w_ra0_ok) begin
      if (BYPASS != 0 && w_wr_ok && waddr == ra0)
        w_rd0 = wdata;
      else
        w_rd0 = r_mem[ra0[IW-1:0]];
    end
  end

  always_comb begin
    w_rd1 = '0;
    if (w_ra1_ok) begin
      if (BYPASS != 0 && w_wr_ok && waddr == ra1)
        w_rd1 = wdata;
      else
        w_rd1 = r_mem[ra1[IW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd0 <= '0;
      r_rd1 <= '0;
    end else begin
      r_rd0 <= w_rd0;
      r_rd1 <= w_rd1;
    end
  end

  assign rd0      = r_rd0;
  assign rd1      = r_rd1;
  assign busy     = w_busy;
  assign clr_done = w_done;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: write-first and read-first builds side by side,
// checked every cycle against an array-based reference model.
module tb_reg_file;

  localparam int W = 8;
  localparam int D = 16;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         we = 1'b0;
  logic         clr_req = 1'b0;
  logic [A-1:0] waddr = '0;
  logic [A-1:0] ra0 = '0;
  logic [A-1:0] ra1 = '0;
  logic [W-1:0] wdata = '0;

  logic [W-1:0] rd0_b, rd1_b, rd0_r, rd1_r;
  logic         busy_b, done_b, busy_r, done_r;

  int vectors = 0;
  int miscompares = 0;
  int stepno = 0;

  int m_mem [D];
  bit m_act = 0;
  int m_idx = 0;
  int e0b, e1b, e0r, e1r;
  int e_busy, e_done;

  always #5 clk = ~clk;

  reg_file #(.WIDTH(W), .DEPTH(D), .BYPASS(1), .AW(A)) u_byp (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr),
    .wdata(wdata), .ra0(ra0), .rd0(rd0_b), .ra1(ra1),
    .rd1(rd1_b), .clr_req(clr_req), .busy(busy_b),
    .clr_done(done_b)
  );

  reg_file #(.WIDTH(W), .DEPTH(D), .BYPASS(0), .AW(A)) u_rdf (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr),
    .wdata(wdata), .ra0(ra0), .rd0(rd0_r), .ra1(ra1),
    .rd1(rd1_r), .clr_req(clr_req), .busy(busy_r),
    .clr_done(done_r)
  );

  function automatic int rdm(int a, bit acc, int wa,
                             int wd, bit byp);
    if (a >= D) return 0;
    if (byp && acc && wa == a) return wd;
    return m_mem[a];
  endfunction

  task automatic model_edge(bit r, bit w, int wa, int wd,
                            int a0, int a1, bit c);
    bit acc;
    if (!r) begin
      e0b = 0; e1b = 0; e0r = 0; e1r = 0;
      m_act = 0; m_idx = 0; e_done = 0;
    end else begin
      acc = w && !m_act && !c && wa < D;
      e0b = rdm(a0, acc, wa, wd, 1);
      e1b = rdm(a1, acc, wa, wd, 1);
      e0r = rdm(a0, acc, wa, wd, 0);
      e1r = rdm(a1, acc, wa, wd, 0);
      e_done = 0;
      if (m_act) begin
        m_mem[m_idx] = 0;
        if (m_idx == D - 1) begin
          m_act = 0;
          e_done = 1;
        end else begin
          m_idx++;
        end
      end else if (c) begin
        m_act = 1;
        m_idx = 0;
      end else if (acc) begin
        m_mem[wa] = wd;
      end
    end
    e_busy = m_act ? 1 : 0;
  endtask

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s step %0d observed=%0h expected=%0h",
             tag, stepno, obs, exp);
    end
  endtask

  task automatic step(bit r, bit w, int wa, int wd,
                      int a0, int a1, bit c);
    @(negedge clk);
    rst_n = r; we = w; clr_req = c;
    waddr = A'(wa); wdata = W'(wd);
    ra0 = A'(a0); ra1 = A'(a1);
    model_edge(r, w, wa, wd, a0, a1, c);
    @(posedge clk);
    #1;
    stepno++;
    chk("rd0_byp", 64'(rd0_b), 64'(e0b));
    chk("rd1_byp", 64'(rd1_b), 64'(e1b));
    chk("rd0_rdf", 64'(rd0_r), 64'(e0r));
    chk("rd1_rdf", 64'(rd1_r), 64'(e1r));
    chk("busy_byp", 64'(busy_b), 64'(e_busy));
    chk("busy_rdf", 64'(busy_r), 64'(e_busy));
    chk("done_byp", 64'(done_b), 64'(e_done));
    chk("done_rdf", 64'(done_r), 64'(e_done));
  endtask

  task automatic fill_random();
    for (int i = 0; i < D; i++)
      step(1, 1, i, int'($urandom_range(0, 255)), 20, 20, 0);
  endtask

  task automatic scan();
    for (int i = 0; i < D; i++)
      step(1, 0, 0, 0, i, D - 1 - i, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 3, 7, 0);
    fill_random();
    scan();

    step(1, 1, 3, 8'hA5, 20, 20, 0);
    step(1, 0, 0, 0, 3, 20, 0);

    step(1, 1, 5, 8'h3C, 5, 5, 0);
    step(1, 0, 0, 0, 5, 5, 0);

    step(1, 1, 0, 8'h11, 20, 20, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 20, 8'h99, 20, 20, 0);
    step(1, 0, 0, 0, 20, 4, 0);

    step(0, 1, 9, 8'h5A, 9, 9, 1);
    step(1, 0, 0, 0, 9, 9, 0);
    step(1, 0, 0, 0, 9, 9, 0);

    fill_random();
    step(1, 1, 7, 8'hFF, 7, 7, 1);
    for (int i = 0; i < D; i++)
      step(1, 1, int'($urandom_range(0, 15)),
           int'($urandom_range(0, 255)),
           int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), i[0]);
    step(1, 0, 0, 0, 7, 7, 0);
    scan();

    fill_random();
    step(1, 0, 0, 0, 20, 20, 1);
    for (int i = 0; i < 5; i++)
      step(1, 0, 0, 0, i, 5, 0);
    step(0, 1, 6, 8'h42, 5, 6, 1);
    step(1, 0, 0, 0, 5, 4, 0);
    scan();

    step(1, 0, 0, 0, 20, 20, 1);
    for (int i = 0; i < D; i++)
      step(1, 0, 0, 0, i, 0, 0);
    step(1, 1, 2, 8'h77, 2, 2, 1);
    for (int i = 0; i < D; i++)
      step(1, 0, 0, 0, 15, i, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) != 0,
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, 19)),
           int'($urandom_range(0, 255)),
           int'($urandom_range(0, 19)),
           int'($urandom_range(0, 19)),
           $urandom_range(0, 29) == 0);
    scan();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
